// File: rtl/fog_pkg.sv
// Shared types and constants for the FOG modulation parameter scheduler.
package fog_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        SETTLE = 2'd2
    } fog_state_e;

    localparam logic [2:0] ADDR_FREQ       = 3'd0;
    localparam logic [2:0] ADDR_AMP_H      = 3'd1;
    localparam logic [2:0] ADDR_AMP_L      = 3'd2;
    localparam logic [2:0] ADDR_POLARITY   = 3'd3;
    localparam logic [2:0] ADDR_WAIT       = 3'd4;
    localparam logic [2:0] ADDR_ERR_OFFSET = 3'd5;
    localparam logic [2:0] ADDR_AVG_SEL    = 3'd6;
    localparam logic [2:0] ADDR_INVALID    = 3'd7;

    typedef struct packed {
        logic [31:0] freq_cnt;
        logic [31:0] amp_h;
        logic [31:0] amp_l;
        logic        polarity;
        logic [31:0] wait_cnt;
        logic [31:0] err_offset;
        logic [31:0] avg_sel;
    } fog_params_t;

    function automatic fog_params_t fog_reset_params(input logic [31:0] freq);
        fog_params_t p;
        p          = '0;
        p.freq_cnt = freq;
        return p;
    endfunction

endpackage

// File: rtl/fog_shadow_regfile.sv
// Shadow parameter set written by the NIOS; decodes the write address.
module fog_shadow_regfile
    import fog_pkg::*;
#(
    parameter logic [31:0] RST_FREQ_CNT = 32'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    output fog_params_t shadow,
    output logic [31:0] freq_next,
    output logic        addr_err
);

    fog_params_t shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        addr_err = 1'b0;
        if (wr_en) begin
            case (wr_addr)
                ADDR_FREQ:       shadow_d.freq_cnt   = wr_data;
                ADDR_AMP_H:      shadow_d.amp_h      = wr_data;
                ADDR_AMP_L:      shadow_d.amp_l      = wr_data;
                ADDR_POLARITY:   shadow_d.polarity   = wr_data[0];
                ADDR_WAIT:       shadow_d.wait_cnt   = wr_data;
                ADDR_ERR_OFFSET: shadow_d.err_offset = wr_data;
                ADDR_AVG_SEL:    shadow_d.avg_sel    = wr_data;
                default:         addr_err            = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_q <= fog_reset_params(RST_FREQ_CNT);
        else     shadow_q <= shadow_d;
    end

    assign shadow = shadow_q;
    // Commit checks look at the post-write value so a same-cycle write is honoured.
    assign freq_next = shadow_d.freq_cnt;

endmodule

// File: rtl/fog_param_scheduler.sv
// Applies a shadowed modulator parameter set atomically on a polarity switch,
// then gates the demodulated error until the loop has settled.
//   state  | meaning
//   IDLE   | settled, error valid, waiting for a commit request
//   ARMED  | commit accepted, waiting for i_step_trig or timeout
//   SETTLE | counting step pulses after a commit (after reset: hold until first commit)
module fog_param_scheduler
    import fog_pkg::*;
#(
    parameter int SETTLE_STEPS = 4,
    parameter int TRIG_TIMEOUT = 1048576,
    parameter int RST_FREQ_CNT = 100
) (
    input  logic        CLOCK_CPU,
    input  logic        RST,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    output logic        o_wr_ready,
    input  logic        i_commit_req,
    input  logic        i_step_trig,
    output logic [31:0] o_freq_cnt,
    output logic [31:0] o_amp_H,
    output logic [31:0] o_amp_L,
    output logic [31:0] o_wait_cnt,
    output logic [31:0] o_err_offset,
    output logic [31:0] o_avg_sel,
    output logic        o_polarity,
    output logic        o_err_gate,
    output logic        o_busy,
    output logic        o_commit_done,
    output logic        o_cfg_err,
    output logic        o_timeout
);

    localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_STEPS);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TRIG_TIMEOUT - 1);
    localparam logic [31:0] RST_FREQ     = 32'(RST_FREQ_CNT);

    fog_state_e  state_q, state_d;
    logic        hold_q, hold_d;
    logic        pend_q, pend_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic        gate_q, gate_d;
    fog_params_t act_q, act_d;
    logic        done_q, done_d;
    logic        cfg_err_q, cfg_err_d;
    logic        timeout_q, timeout_d;

    fog_params_t shadow;
    logic [31:0] freq_next;
    logic        addr_err;
    logic        wr_ready;
    logic        commit_ok;
    logic        can_start;
    logic        do_commit;
    logic        pend_now;
    logic [7:0]  step_inc;

    assign wr_ready = (state_q != ARMED);

    fog_shadow_regfile #(
        .RST_FREQ_CNT(RST_FREQ)
    ) u_shadow (
        .clk      (CLOCK_CPU),
        .rst      (RST),
        .wr_en    (i_wr_en & wr_ready),
        .wr_addr  (i_wr_addr),
        .wr_data  (i_wr_data),
        .shadow   (shadow),
        .freq_next(freq_next),
        .addr_err (addr_err)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        to_cnt_d   = to_cnt_q;
        step_cnt_d = step_cnt_q;
        gate_d     = gate_q;
        act_d      = act_q;
        done_d     = 1'b0;
        cfg_err_d  = addr_err;
        timeout_d  = timeout_q;
        do_commit  = 1'b0;
        commit_ok  = (freq_next != 32'd0);
        pend_now   = pend_q | i_commit_req;
        step_inc   = (step_cnt_q == 8'hFF) ? step_cnt_q : step_cnt_q + 8'd1;
        // The post-reset SETTLE behaves like IDLE for commit requests but keeps the gate low.
        can_start  = (state_q == IDLE) || ((state_q == SETTLE) && hold_q);

        if (can_start) begin
            if (i_commit_req) begin
                if (commit_ok) begin
                    state_d   = ARMED;
                    hold_d    = 1'b0;
                    to_cnt_d  = '0;
                    timeout_d = 1'b0;
                end else begin
                    cfg_err_d = 1'b1;
                end
            end
        end else begin
            case (state_q)
                ARMED: begin
                    if (i_step_trig) begin
                        do_commit = 1'b1;
                    end else if (to_cnt_q == TIMEOUT_LAST) begin
                        do_commit = 1'b1;
                        timeout_d = 1'b1;
                    end else if (to_cnt_q != '1) begin
                        to_cnt_d = to_cnt_q + 32'd1;
                    end
                end
                SETTLE: begin
                    if (i_commit_req) begin
                        pend_d    = 1'b1;
                        timeout_d = 1'b0;
                    end
                    if (i_step_trig) begin
                        step_cnt_d = step_inc;
                        if (step_inc == SETTLE_LAST) begin
                            gate_d  = 1'b1;
                            pend_d  = 1'b0;
                            state_d = IDLE;
                            if (pend_now) begin
                                if (commit_ok) begin
                                    state_d  = ARMED;
                                    to_cnt_d = '0;
                                end else begin
                                    cfg_err_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_d = SETTLE;
            endcase
        end

        if (do_commit) begin
            act_d      = shadow;
            done_d     = 1'b1;
            gate_d     = 1'b0;
            state_d    = SETTLE;
            step_cnt_d = '0;
            to_cnt_d   = '0;
        end
    end

    always_ff @(posedge CLOCK_CPU or posedge RST) begin
        if (RST) begin
            state_q    <= SETTLE;
            hold_q     <= 1'b1;
            pend_q     <= 1'b0;
            to_cnt_q   <= '0;
            step_cnt_q <= '0;
            gate_q     <= 1'b0;
            act_q      <= fog_reset_params(RST_FREQ);
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            to_cnt_q   <= to_cnt_d;
            step_cnt_q <= step_cnt_d;
            gate_q     <= gate_d;
            act_q      <= act_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_wr_ready    = wr_ready;
    assign o_freq_cnt    = act_q.freq_cnt;
    assign o_amp_H       = act_q.amp_h;
    assign o_amp_L       = act_q.amp_l;
    assign o_polarity    = act_q.polarity;
    assign o_wait_cnt    = act_q.wait_cnt;
    assign o_err_offset  = act_q.err_offset;
    assign o_avg_sel     = act_q.avg_sel;
    assign o_err_gate    = gate_q;
    assign o_busy        = (state_q != IDLE) || pend_q;
    assign o_commit_done = done_q;
    assign o_cfg_err     = cfg_err_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_fog_param_scheduler.sv
// Directed bench for fog_param_scheduler with a commit scoreboard.
module tb_fog_param_scheduler;

    localparam int SETTLE_STEPS = 4;
    localparam int TRIG_TIMEOUT = 64;
    localparam int RST_FREQ_CNT = 100;

    typedef logic [6:0][31:0] pset_t;

    logic        CLOCK_CPU = 1'b0;
    logic        RST = 1'b1;
    logic        i_wr_en, i_commit_req, i_step_trig;
    logic [2:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        o_wr_ready, o_polarity, o_err_gate, o_busy, o_commit_done, o_cfg_err, o_timeout;
    logic [31:0] o_freq_cnt, o_amp_H, o_amp_L, o_wait_cnt, o_err_offset, o_avg_sel;

    pset_t       exp_q[$];
    logic [31:0] m_sh[7];
    int          n_tests = 0;
    int          n_fail  = 0;

    fog_param_scheduler #(
        .SETTLE_STEPS(SETTLE_STEPS),
        .TRIG_TIMEOUT(TRIG_TIMEOUT),
        .RST_FREQ_CNT(RST_FREQ_CNT)
    ) dut (
        .CLOCK_CPU    (CLOCK_CPU),
        .RST          (RST),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .o_wr_ready   (o_wr_ready),
        .i_commit_req (i_commit_req),
        .i_step_trig  (i_step_trig),
        .o_freq_cnt   (o_freq_cnt),
        .o_amp_H      (o_amp_H),
        .o_amp_L      (o_amp_L),
        .o_wait_cnt   (o_wait_cnt),
        .o_err_offset (o_err_offset),
        .o_avg_sel    (o_avg_sel),
        .o_polarity   (o_polarity),
        .o_err_gate   (o_err_gate),
        .o_busy       (o_busy),
        .o_commit_done(o_commit_done),
        .o_cfg_err    (o_cfg_err),
        .o_timeout    (o_timeout)
    );

    always #5 CLOCK_CPU = ~CLOCK_CPU;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_actives(input string tag, input pset_t e);
        check({tag, "_freq"},   o_freq_cnt,           e[0]);
        check({tag, "_amp_h"},  o_amp_H,              e[1]);
        check({tag, "_amp_l"},  o_amp_L,              e[2]);
        check({tag, "_pol"},    {31'd0, o_polarity},  e[3]);
        check({tag, "_wait"},   o_wait_cnt,           e[4]);
        check({tag, "_erroff"}, o_err_offset,         e[5]);
        check({tag, "_avg"},    o_avg_sel,            e[6]);
    endtask

    function automatic pset_t m_pack();
        pset_t p;
        for (int i = 0; i < 7; i++) p[i] = m_sh[i];
        p[3] = {31'd0, m_sh[3][0]};
        return p;
    endfunction

    function automatic pset_t reset_set();
        pset_t p;
        p    = '0;
        p[0] = 32'(RST_FREQ_CNT);
        return p;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 7; i++) m_sh[i] = 32'd0;
        m_sh[0] = 32'(RST_FREQ_CNT);
    endtask

    task automatic check_reset_vals(input string tag);
        check_actives(tag, reset_set());
        check({tag, "_gate"},    o_err_gate,    0);
        check({tag, "_busy"},    o_busy,        1);
        check({tag, "_done"},    o_commit_done, 0);
        check({tag, "_cfgerr"},  o_cfg_err,     0);
        check({tag, "_timeout"}, o_timeout,     0);
        check({tag, "_wrrdy"},   o_wr_ready,    1);
    endtask

    task automatic cyc();
        @(negedge CLOCK_CPU);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input bit accepted);
        i_wr_en   = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
        check("wr_ready", o_wr_ready, {31'd0, accepted});
        if (accepted && a != 3'd7) m_sh[a] = d;
        cyc();
        i_wr_en = 1'b0;
    endtask

    task automatic commit(input bit expect_commit);
        i_commit_req = 1'b1;
        if (expect_commit) exp_q.push_back(m_pack());
        cyc();
        i_commit_req = 1'b0;
    endtask

    task automatic trig();
        i_step_trig = 1'b1;
        cyc();
        i_step_trig = 1'b0;
        cyc();
    endtask

    // Scoreboard: every commit edge must match the oldest expected parameter set.
    always @(negedge CLOCK_CPU) begin
        if (!RST && o_commit_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit", {31'd0, o_commit_done}, 0);
            end else begin
                check_actives("commit", exp_q.pop_front());
                check("gate_low_at_commit", {31'd0, o_err_gate}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_wr_en = 0; i_wr_addr = 0; i_wr_data = 0; i_commit_req = 0; i_step_trig = 0;
        RST = 1'b1;
        reset_model();
        repeat (3) cyc();
        check_reset_vals("rst_hold");
        RST = 1'b0;
        cyc();
        check_reset_vals("rst_release");
        i_step_trig = 1'b1; cyc(); i_step_trig = 1'b0;
        check("hold_no_count_gate", o_err_gate, 0);

        // Basic commit with a full parameter set
        wr(3'd0, 32'd200, 1);
        wr(3'd1, 32'h1111, 1);
        wr(3'd2, 32'h2222, 1);
        wr(3'd3, 32'h3, 1);
        wr(3'd4, 32'd5, 1);
        wr(3'd5, 32'd7, 1);
        wr(3'd6, 32'd3, 1);
        commit(1);
        check("armed_wr_ready", o_wr_ready, 0);
        check("armed_busy", o_busy, 1);
        check("armed_freq_old", o_freq_cnt, 100);
        repeat (10) cyc();
        check("armed_wait_freq", o_freq_cnt, 100);
        i_step_trig = 1'b1; cyc(); i_step_trig = 1'b0;
        check("commit_freq", o_freq_cnt, 200);
        check("commit_done", o_commit_done, 1);
        cyc();
        check("commit_done_pulse", o_commit_done, 0);
        repeat (3) trig();
        check("settle_gate_3", o_err_gate, 0);
        i_step_trig = 1'b1; cyc(); i_step_trig = 1'b0;
        check("settle_gate_4", o_err_gate, 1);
        check("idle_busy", o_busy, 0);
        check("idle_wr_ready", o_wr_ready, 1);

        // Zero frequency commit is rejected
        wr(3'd0, 32'd0, 1);
        commit(0);
        check("rej_cfg_err", o_cfg_err, 1);
        check("rej_busy", o_busy, 0);
        check("rej_wr_ready", o_wr_ready, 1);
        check("rej_freq_kept", o_freq_cnt, 200);
        cyc();
        check("rej_cfg_err_pulse", o_cfg_err, 0);
        trig(); trig();
        check("idle_freq_kept", o_freq_cnt, 200);

        // Write and commit in the same cycle, then forced commit by timeout
        i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 32'd300; i_commit_req = 1'b1;
        m_sh[0] = 32'd300;
        exp_q.push_back(m_pack());
        cyc();
        i_wr_en = 1'b0; i_commit_req = 1'b0;
        check("same_cycle_armed", o_wr_ready, 0);
        check("armed_gate_kept", o_err_gate, 1);
        for (int k = 0; k < TRIG_TIMEOUT - 1; k++) begin
            cyc();
            check("to_early", o_commit_done, 0);
        end
        cyc();
        check("to_commit", o_commit_done, 1);
        check("to_flag", o_timeout, 1);
        check("to_freq", o_freq_cnt, 300);
        trig();
        check("to_sticky", o_timeout, 1);

        // Commit request during SETTLE becomes pending
        wr(3'd1, 32'hAAAA, 1);
        commit(1);
        check("pend_busy", o_busy, 1);
        check("to_cleared", o_timeout, 0);
        trig(); trig();
        check("pend_gate_3", o_err_gate, 0);
        i_step_trig = 1'b1; cyc(); i_step_trig = 1'b0;
        check("pend_gate_armed", o_err_gate, 1);
        check("pend_armed", o_wr_ready, 0);
        check("pend_armed_busy", o_busy, 1);
        wr(3'd1, 32'hBBBB, 0);
        commit(0);
        cyc();
        i_step_trig = 1'b1; cyc(); i_step_trig = 1'b0;
        check("pend_commit_amp", o_amp_H, 32'hAAAA);
        check("pend_commit_done", o_commit_done, 1);
        repeat (4) trig();
        check("armed_req_ignored_busy", o_busy, 0);
        check("armed_req_ignored_rdy", o_wr_ready, 1);

        // Invalid address
        wr(3'd7, 32'hDEAD, 1);
        check("addr7_cfg_err", o_cfg_err, 1);
        cyc();
        check("addr7_cfg_err_pulse", o_cfg_err, 0);
        check("addr7_amp_kept", o_amp_H, 32'hAAAA);

        // Trigger on the IDLE->ARMED cycle must not commit
        i_commit_req = 1'b1; i_step_trig = 1'b1;
        exp_q.push_back(m_pack());
        cyc();
        i_commit_req = 1'b0; i_step_trig = 1'b0;
        check("entry_trig_no_commit", o_commit_done, 0);
        cyc();
        check("entry_trig_armed", o_wr_ready, 0);
        i_step_trig = 1'b1; cyc(); i_step_trig = 1'b0;
        check("entry_commit_done", o_commit_done, 1);

        // Reset in SETTLE with a pending commit and dirty shadow
        i_commit_req = 1'b1; cyc(); i_commit_req = 1'b0;
        check("pre_rst_busy", o_busy, 1);
        wr(3'd0, 32'd555, 1);
        #2;
        RST = 1'b1;
        exp_q.delete();
        reset_model();
        #1;
        check_reset_vals("rst_async");
        cyc();
        RST = 1'b0;
        cyc();
        check_reset_vals("rst_after");
        commit(1);
        i_step_trig = 1'b1; cyc(); i_step_trig = 1'b0;
        check("post_rst_commit_freq", o_freq_cnt, 100);
        repeat (4) trig();
        check("post_rst_gate", o_err_gate, 1);
        check("post_rst_idle", o_busy, 0);

        cyc();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
